// File: rtl/char_buffer_writer.sv
// char_buffer_writer: owner of the 16x16 text RAM read by the character overlay.
// Places a valid/ready byte stream at a cursor and serves a 1-cycle read port.
module char_buffer_writer #(
    parameter logic [6:0] FILL_CHAR      = 7'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic [7:0] cursor_xy,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] CLEAR     = 1'b1;
    localparam logic [0:0] RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [0:0] state;
    logic [0:0] state_nx;
    logic [7:0] clr_cnt;
    logic [7:0] clr_cnt_nx;
    logic [7:0] cursor_nx;
    logic [6:0] mem [256];
    logic       we;
    logic [7:0] waddr;
    logic [6:0] wdata;
    logic       accept;
    logic       printable;
    logic [3:0] row;
    logic [3:0] col;

    assign row        = cursor_xy[7:4];
    assign col        = cursor_xy[3:0];
    assign data_ready = (state == IDLE);
    assign busy       = (state == CLEAR);
    assign accept     = data_valid && data_ready;
    assign printable  = (data_in >= 8'h20) && (data_in <= 8'h7E);

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        cursor_nx  = cursor_xy;
        we         = 1'b0;
        waddr      = cursor_xy;
        wdata      = data_in[6:0];
        if (state == CLEAR) begin
            we         = 1'b1;
            waddr      = clr_cnt;
            wdata      = FILL_CHAR;
            clr_cnt_nx = clr_cnt + 8'd1;
            if (clr_cnt == 8'hFF) begin
                state_nx = IDLE;
            end
        end else if (clear_req) begin
            // A byte accepted in the same cycle is dropped: clear wins
            state_nx   = CLEAR;
            clr_cnt_nx = '0;
            cursor_nx  = '0;
        end else if (accept) begin
            unique case (1'b1)
                printable: begin
                    we        = 1'b1;
                    cursor_nx = cursor_xy + 8'd1;
                end
                (data_in == 8'h0A): cursor_nx = {row + 4'd1, 4'h0};
                (data_in == 8'h0D): cursor_nx = {row, 4'h0};
                (data_in == 8'h08): begin
                    if (col != 4'h0) begin
                        cursor_nx = {row, col - 4'd1};
                        we        = 1'b1;
                        waddr     = {row, col - 4'd1};
                        wdata     = FILL_CHAR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= RST_STATE;
            clr_cnt   <= '0;
            cursor_xy <= '0;
        end else begin
            state     <= state_nx;
            clr_cnt   <= clr_cnt_nx;
            cursor_xy <= cursor_nx;
        end
    end

    // RAM is not reset; a same-address read returns the pre-write data
    always_ff @(posedge pclk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            char_code <= '0;
        end else begin
            char_code <= mem[char_xy];
        end
    end
endmodule

// File: tb/tb_char_buffer_writer.sv
// Testbench for char_buffer_writer: directed scenarios plus a randomized
// run checked against a row/column text-screen model.
module tb_char_buffer_writer;
    localparam int FILL = 'h20;

    logic       pclk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       clear_req = 1'b0;
    logic       busy;
    logic [7:0] cursor_xy;
    logic [7:0] char_xy = 8'h00;
    logic [6:0] char_code;

    int n_checks = 0;
    int n_fail = 0;

    int m_mem [256];
    int m_row;
    int m_col;
    int m_left;
    int m_code;

    char_buffer_writer dut (
        .pclk      (pclk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .clear_req (clear_req),
        .busy      (busy),
        .cursor_xy (cursor_xy),
        .char_xy   (char_xy),
        .char_code (char_code)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] m_xy();
        return 8'(m_row * 16 + m_col);
    endfunction

    function automatic void apply_byte(input int b);
        if (b >= 'h20 && b <= 'h7E) begin
            m_mem[m_row * 16 + m_col] = b;
            m_col++;
            if (m_col == 16) begin
                m_col = 0;
                m_row = (m_row + 1) % 16;
            end
        end else if (b == 'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 16;
        end else if (b == 'h0D) begin
            m_col = 0;
        end else if (b == 'h08 && m_col > 0) begin
            m_col--;
            m_mem[m_row * 16 + m_col] = FILL;
        end
    endfunction

    // Advance the model by one clock edge using the inputs held now, then step
    task automatic tick();
        if (rst) begin
            m_code = 0;
            m_row  = 0;
            m_col  = 0;
            m_left = 256;
        end else begin
            m_code = m_mem[char_xy];
            if (m_left > 0) begin
                m_mem[256 - m_left] = FILL;
                m_left--;
            end else if (clear_req) begin
                m_left = 256;
                m_row  = 0;
                m_col  = 0;
            end else if (data_valid) begin
                apply_byte(int'(data_in));
            end
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic read_ram(input logic [7:0] a, output logic [6:0] v);
        char_xy = a;
        tick();
        v = char_code;
    endtask

    task automatic goto(input int r, input int c);
        send_byte(8'h0D);
        while (m_row != r) send_byte(8'h0A);
        while (m_col != c) send_byte(8'h2E);
    endtask

    task automatic test_reset();
        int cnt;
        logic [6:0] v;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (char_code !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_code: got %h expected 00", char_code);
        end
        n_checks++;
        if (cursor_xy !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cursor: got %h expected 00", cursor_xy);
        end
        n_checks++;
        if (busy !== 1'b1 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy %b ready %b expected 1 0", busy, data_ready);
        end
        cnt = 1;
        while (busy === 1'b1 && cnt < 400) begin
            tick();
            if (busy === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL reset_clear_len: got %0d cycles expected 256", cnt);
        end
        n_checks++;
        if (data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", data_ready);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            read_ram(8'(a), v);
            n_checks++;
            if (v !== 7'h20) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL reset_fill[%02h]: got %h expected 20", a, v);
            end
        end
    endtask

    task automatic test_print();
        logic [6:0] v;
        send_byte(8'h41);
        send_byte(8'h42);
        n_checks++;
        if (cursor_xy !== 8'h02) begin
            n_fail++;
            $display("FAIL print_cursor: got %h expected 02", cursor_xy);
        end
        read_ram(8'h00, v);
        n_checks++;
        if (v !== 7'h41) begin
            n_fail++;
            $display("FAIL print_ram0: got %h expected 41", v);
        end
        read_ram(8'h01, v);
        n_checks++;
        if (v !== 7'h42) begin
            n_fail++;
            $display("FAIL print_ram1: got %h expected 42", v);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] v;
        goto(0, 15);
        send_byte(8'h43);
        n_checks++;
        if (cursor_xy !== 8'h10) begin
            n_fail++;
            $display("FAIL wrap_col: got %h expected 10", cursor_xy);
        end
        read_ram(8'h0F, v);
        n_checks++;
        if (v !== 7'h43) begin
            n_fail++;
            $display("FAIL wrap_ram0f: got %h expected 43", v);
        end
        goto(15, 15);
        send_byte(8'h44);
        n_checks++;
        if (cursor_xy !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_screen: got %h expected 00", cursor_xy);
        end
        read_ram(8'hFF, v);
        n_checks++;
        if (v !== 7'h44) begin
            n_fail++;
            $display("FAIL wrap_ramff: got %h expected 44", v);
        end
    endtask

    task automatic test_control();
        logic [6:0] v;
        goto(3, 5);
        send_byte(8'h0D);
        n_checks++;
        if (cursor_xy !== 8'h30) begin
            n_fail++;
            $display("FAIL ctl_cr: got %h expected 30", cursor_xy);
        end
        send_byte(8'h0A);
        n_checks++;
        if (cursor_xy !== 8'h40) begin
            n_fail++;
            $display("FAIL ctl_lf: got %h expected 40", cursor_xy);
        end
        goto(15, 7);
        send_byte(8'h0A);
        n_checks++;
        if (cursor_xy !== 8'h00) begin
            n_fail++;
            $display("FAIL ctl_lf_wrap: got %h expected 00", cursor_xy);
        end
        goto(4, 2);
        send_byte(8'h08);
        n_checks++;
        if (cursor_xy !== 8'h41) begin
            n_fail++;
            $display("FAIL ctl_bs: got %h expected 41", cursor_xy);
        end
        read_ram(8'h41, v);
        n_checks++;
        if (v !== 7'h20) begin
            n_fail++;
            $display("FAIL ctl_bs_fill: got %h expected 20", v);
        end
        goto(4, 0);
        send_byte(8'h08);
        n_checks++;
        if (cursor_xy !== 8'h40) begin
            n_fail++;
            $display("FAIL ctl_bs_col0: got %h expected 40", cursor_xy);
        end
        read_ram(8'h40, v);
        n_checks++;
        if (v !== 7'h2E) begin
            n_fail++;
            $display("FAIL ctl_bs_nowrite: got %h expected 2e", v);
        end
        send_byte(8'h07);
        n_checks++;
        if (cursor_xy !== 8'h40) begin
            n_fail++;
            $display("FAIL ctl_other: got %h expected 40", cursor_xy);
        end
    endtask

    task automatic test_clear_collision();
        int cnt;
        logic [6:0] v;
        char_xy    = 8'h40;
        data_valid = 1'b1;
        data_in    = 8'h58;
        clear_req  = 1'b1;
        tick();
        clear_req = 1'b0;
        data_in   = 8'h5A;
        n_checks++;
        if (cursor_xy !== 8'h00 || busy !== 1'b1 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_start: cursor %h busy %b ready %b expected 00 1 0",
                     cursor_xy, busy, data_ready);
        end
        tick();
        n_checks++;
        if (char_code !== 7'h2E) begin
            n_fail++;
            $display("FAIL clr_discard: got %h expected 2e", char_code);
        end
        cnt = 2;
        while (busy === 1'b1 && cnt < 600) begin
            clear_req = (cnt == 100);
            tick();
            clear_req = 1'b0;
            if (busy === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL clr_len: got %0d cycles expected 256", cnt);
        end
        n_checks++;
        if (cursor_xy !== 8'h00 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_held_byte: cursor %h ready %b expected 00 1",
                     cursor_xy, data_ready);
        end
        tick();
        data_valid = 1'b0;
        n_checks++;
        if (cursor_xy !== 8'h01) begin
            n_fail++;
            $display("FAIL clr_after_cursor: got %h expected 01", cursor_xy);
        end
        read_ram(8'h00, v);
        n_checks++;
        if (v !== 7'h5A) begin
            n_fail++;
            $display("FAIL clr_after_ram: got %h expected 5a", v);
        end
        read_ram(8'h40, v);
        n_checks++;
        if (v !== 7'h20) begin
            n_fail++;
            $display("FAIL clr_wiped: got %h expected 20", v);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        send_byte(8'h41);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 1; i < 50; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cursor_xy !== 8'h00 || char_code !== 7'h00) begin
            n_fail++;
            $display("FAIL rstmid_state: busy %b cursor %h code %h expected 1 00 00",
                     busy, cursor_xy, char_code);
        end
        cnt = 1;
        while (busy === 1'b1 && cnt < 600) begin
            tick();
            if (busy === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL rstmid_len: got %0d cycles expected 256", cnt);
        end
        char_xy    = 8'h00;
        data_valid = 1'b1;
        data_in    = 8'h41;
        tick();
        data_valid = 1'b0;
        n_checks++;
        if (char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL rw_old: got %h expected 20", char_code);
        end
        tick();
        n_checks++;
        if (char_code !== 7'h41) begin
            n_fail++;
            $display("FAIL rw_new: got %h expected 41", char_code);
        end
    endtask

    task automatic test_random();
        int sel;
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            sel        = int'($urandom_range(0, 9));
            data_valid = ($urandom_range(0, 3) != 0);
            clear_req  = ($urandom_range(0, 199) == 0);
            char_xy    = 8'($urandom_range(0, 255));
            if (sel <= 5) data_in = 8'($urandom_range('h20, 'h7E));
            else if (sel == 6) data_in = 8'h0A;
            else if (sel == 7) data_in = 8'h0D;
            else if (sel == 8) data_in = 8'h08;
            else data_in = 8'($urandom_range(0, 255));
            tick();
            n_checks++;
            if (char_code !== 7'(m_code) || cursor_xy !== m_xy() ||
                busy !== (m_left > 0) || data_ready !== (m_left == 0)) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand[%0d]: code %h cur %h busy %b rdy %b expected %h %h %b %b",
                             i, char_code, cursor_xy, busy, data_ready,
                             7'(m_code), m_xy(), m_left > 0, m_left == 0);
            end
        end
        data_valid = 1'b0;
        clear_req  = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) m_mem[a] = -1;
        m_row  = 0;
        m_col  = 0;
        m_left = 0;
        m_code = 0;
        @(posedge pclk);
        #1;
        test_reset();
        test_print();
        test_wrap();
        test_control();
        test_clear_collision();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
